// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard controller and the datapath.
// Member names follow the controller's external signal names.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] ex_rs1;
    logic [ADDR_W-1:0] ex_rs2;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              ex_mdu_op;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_reg_write;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_reg_write;
    logic              mdu_done;

    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              ex_mem_en;
    logic              if_id_clr;
    logic              id_ex_clr;
    logic              ex_mem_clr;
    logic              mdu_start;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_op, mem_rd, mem_reg_write,
               wb_rd, wb_reg_write, mdu_done,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_clr, id_ex_clr,
               ex_mem_clr, mdu_start, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_op, mem_rd, mem_reg_write,
               wb_rd, wb_reg_write, mdu_done,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_clr, id_ex_clr,
               ex_mem_clr, mdu_start, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch flushes,
// MDU freeze, EX operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             w_load_use;
    logic             w_flush;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] rs,
        input logic [ADDR_W-1:0] mem_rd,
        input logic              mem_we,
        input logic [ADDR_W-1:0] wb_rd,
        input logic              wb_we
    );
        if (mem_we && mem_rd != '0 && mem_rd == rs)
            return 2'b10;
        else if (wb_we && wb_rd != '0 && wb_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    end

    always_comb begin
        w_next_state   = r_state;
        w_flush        = 1'b0;
        bus.pc_en      = 1'b1;
        bus.if_id_en   = 1'b1;
        bus.id_ex_en   = 1'b1;
        bus.ex_mem_en  = 1'b1;
        bus.if_id_clr  = 1'b0;
        bus.id_ex_clr  = 1'b0;
        bus.ex_mem_clr = 1'b0;
        bus.mdu_start  = 1'b0;
        bus.fwd_a      = 2'b00;
        bus.fwd_b      = 2'b00;

        if (!rst) begin
            // Hold everything quiet while in reset.
            w_next_state  = ST_RUN;
            bus.pc_en     = 1'b0;
            bus.if_id_en  = 1'b0;
            bus.id_ex_en  = 1'b0;
            bus.ex_mem_en = 1'b0;
        end else begin
            bus.fwd_a = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write,
                                bus.wb_rd, bus.wb_reg_write);
            bus.fwd_b = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write,
                                bus.wb_rd, bus.wb_reg_write);
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        w_flush       = 1'b1;
                        bus.if_id_clr = 1'b1;
                        bus.id_ex_clr = 1'b1;
                    end else if (bus.ex_mdu_op) begin
                        w_next_state   = ST_MDU_WAIT;
                        bus.mdu_start  = 1'b1;
                        bus.pc_en      = 1'b0;
                        bus.if_id_en   = 1'b0;
                        bus.id_ex_en   = 1'b0;
                        bus.ex_mem_clr = 1'b1;
                    end else if (w_load_use) begin
                        bus.pc_en     = 1'b0;
                        bus.if_id_en  = 1'b0;
                        bus.id_ex_clr = 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        w_next_state = ST_RUN;
                    end else begin
                        bus.pc_en      = 1'b0;
                        bus.if_id_en   = 1'b0;
                        bus.id_ex_en   = 1'b0;
                        bus.ex_mem_clr = 1'b1;
                    end
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (!bus.pc_en && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random
// phase, compared against a mode-based behavioural model.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(32)) bus ();
    pipe_hazard_ctrl_if #(.ADDR_W(5), .CNT_W(4))  bus4 ();

    pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.id_rs1          = bus.id_rs1;
    assign bus4.id_rs2          = bus.id_rs2;
    assign bus4.ex_rs1          = bus.ex_rs1;
    assign bus4.ex_rs2          = bus.ex_rs2;
    assign bus4.ex_rd           = bus.ex_rd;
    assign bus4.ex_mem_read     = bus.ex_mem_read;
    assign bus4.ex_branch_taken = bus.ex_branch_taken;
    assign bus4.ex_mdu_op       = bus.ex_mdu_op;
    assign bus4.mem_rd          = bus.mem_rd;
    assign bus4.mem_reg_write   = bus.mem_reg_write;
    assign bus4.wb_rd           = bus.wb_rd;
    assign bus4.wb_reg_write    = bus.wb_reg_write;
    assign bus4.mdu_done        = bus.mdu_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: control vector {pc,if_id,id_ex,ex_mem en, if_id,id_ex,ex_mem clr, start}
    localparam logic [7:0] M_QUIET  = 8'b0000_000_0;
    localparam logic [7:0] M_NORMAL = 8'b1111_000_0;
    localparam logic [7:0] M_FREEZE = 8'b0001_001_0;
    localparam logic [7:0] M_LAUNCH = 8'b0001_001_1;
    localparam logic [7:0] M_FLUSH  = 8'b1111_110_0;
    localparam logic [7:0] M_BUBBLE = 8'b0011_010_0;

    bit          m_busy  = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic logic [7:0] ref_ctl();
        bit lu;
        if (!rst) return M_QUIET;
        lu = bus.ex_mem_read && bus.ex_rd != 0 &&
             (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        if (m_busy) return bus.mdu_done ? M_NORMAL : M_FREEZE;
        if (bus.ex_branch_taken) return M_FLUSH;
        if (bus.ex_mdu_op) return M_LAUNCH;
        if (lu) return M_BUBBLE;
        return M_NORMAL;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (!rst) return 2'b00;
        if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == rs) return 2'b10;
        if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] obs_ctl();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                bus.if_id_clr, bus.id_ex_clr, bus.ex_mem_clr, bus.mdu_start};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ":stall"}, 64'(bus.stall_cnt), 64'(m_stall));
        chk({tag, ":flush"}, 64'(bus.flush_cnt), 64'(m_flush));
        chk({tag, ":stall4"}, 64'(bus4.stall_cnt), 64'((m_stall > 15) ? 15 : m_stall));
        chk({tag, ":flush4"}, 64'(bus4.flush_cnt), 64'((m_flush > 15) ? 15 : m_flush));
    endtask

    // Inputs are set just after a rising edge; outputs are checked mid-cycle,
    // counters just after the following edge.
    task automatic step(input string tag);
        logic [7:0] e;
        #2;
        e = ref_ctl();
        chk({tag, ":ctl"}, 64'(obs_ctl()), 64'(e));
        chk({tag, ":fwd_a"}, 64'(bus.fwd_a), 64'(ref_fwd(bus.ex_rs1)));
        chk({tag, ":fwd_b"}, 64'(bus.fwd_b), 64'(ref_fwd(bus.ex_rs2)));
        @(posedge clk);
        if (rst) begin
            if (e[7] == 1'b0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (e == M_FLUSH && m_flush != 32'hFFFF_FFFF) m_flush++;
            if (e == M_LAUNCH) m_busy = 1'b1;
            else if (m_busy && bus.mdu_done) m_busy = 1'b0;
        end
        #1;
        chk_cnt(tag);
    endtask

    task automatic mid_reset(input string tag);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_stall = 0; m_flush = 0;
        #1;
        chk({tag, ":ctl"}, 64'(obs_ctl()), 64'(M_QUIET));
        chk({tag, ":fwd"}, 64'({bus.fwd_a, bus.fwd_b}), 64'(0));
        chk_cnt(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0;
        bus.ex_rd = 0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
        bus.ex_mdu_op = 0; bus.mem_rd = 0; bus.mem_reg_write = 0;
        bus.wb_rd = 0; bus.wb_reg_write = 0; bus.mdu_done = 0;
    endtask

    initial begin
        idle_inputs();
        bus.mem_rd = 3; bus.mem_reg_write = 1; bus.ex_rs1 = 3;
        #3;
        chk("reset:ctl", 64'(obs_ctl()), 64'(M_QUIET));
        chk("reset:fwd", 64'({bus.fwd_a, bus.fwd_b}), 64'(0));
        chk_cnt("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();

        // Load-use on rs1, then the same with ex_rd = 0
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5;
        step("loaduse");
        chk("loaduse:stall_is_1", 64'(bus.stall_cnt), 64'(1));
        bus.ex_rd = 0; bus.id_rs1 = 0;
        step("loaduse_x0");
        bus.ex_rd = 9; bus.id_rs1 = 1; bus.id_rs2 = 9;
        step("loaduse_rs2");

        // Branch beats load-use
        bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_rs2 = 0; bus.ex_branch_taken = 1;
        step("branch_lu");
        bus.ex_branch_taken = 0; bus.ex_mem_read = 0;
        chk("branch_lu:flush_is_1", 64'(bus.flush_cnt), 64'(1));

        // MDU op, done three cycles after start
        mid_reset("pre_mdu");
        bus.ex_mdu_op = 1;
        step("mdu_start");
        bus.ex_branch_taken = 1;
        step("mdu_w1");
        bus.ex_branch_taken = 0;
        step("mdu_w2");
        bus.mdu_done = 1;
        step("mdu_done");
        bus.mdu_done = 0; bus.ex_mdu_op = 0;
        chk("mdu:stall_is_3", 64'(bus.stall_cnt), 64'(3));
        step("mdu_after");

        // Back-to-back MDU op: done=1 in N=1 case, new op re-launches
        bus.ex_mdu_op = 1;
        step("mdu2_start");
        bus.mdu_done = 1;
        step("mdu2_done");
        bus.mdu_done = 0;
        step("mdu3_start");
        bus.mdu_done = 1; bus.ex_mdu_op = 0;
        step("mdu3_done");
        bus.mdu_done = 1;
        step("done_in_run");
        bus.mdu_done = 0;

        // Forwarding
        bus.mem_rd = 7; bus.wb_rd = 7; bus.ex_rs1 = 7; bus.ex_rs2 = 7;
        bus.mem_reg_write = 1; bus.wb_reg_write = 1;
        step("fwd_mem");
        chk("fwd_mem:a_is_10", 64'(bus.fwd_a), 64'(2));
        bus.mem_reg_write = 0;
        step("fwd_wb");
        chk("fwd_wb:a_is_01", 64'(bus.fwd_a), 64'(1));
        bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_rs1 = 0; bus.mem_reg_write = 1;
        step("fwd_x0");
        idle_inputs();

        // Reset pulse inside MDU_WAIT, then a stray done
        bus.ex_mdu_op = 1;
        step("rstmdu_start");
        bus.ex_mdu_op = 0;
        step("rstmdu_wait");
        mid_reset("rstmdu_rst");
        bus.mdu_done = 1;
        step("rstmdu_done");
        bus.mdu_done = 0;
        step("rstmdu_after");

        // 20 consecutive stalls: 4-bit counter saturates at 15
        mid_reset("pre_sat");
        bus.ex_mem_read = 1; bus.ex_rd = 4; bus.id_rs2 = 4;
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat:stall4_is_15", 64'(bus4.stall_cnt), 64'(15));
        chk("sat:stall_is_20", 64'(bus.stall_cnt), 64'(20));
        idle_inputs();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            bus.id_rs1 = 5'($urandom_range(0, 7));
            bus.id_rs2 = 5'($urandom_range(0, 7));
            bus.ex_rs1 = 5'($urandom_range(0, 7));
            bus.ex_rs2 = 5'($urandom_range(0, 7));
            bus.ex_rd = 5'($urandom_range(0, 7));
            bus.mem_rd = 5'($urandom_range(0, 7));
            bus.wb_rd = 5'($urandom_range(0, 7));
            bus.ex_mem_read = ($urandom_range(0, 2) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            bus.ex_mdu_op = ($urandom_range(0, 7) == 0);
            bus.mem_reg_write = $urandom_range(0, 1) == 1;
            bus.wb_reg_write = $urandom_range(0, 1) == 1;
            bus.mdu_done = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
